// File: rtl/pagerank_fx_pkg.sv
// Fixed-point types, constants and helpers shared by the PageRank gather/accumulate stage.
// Ranks and contributions are unsigned Q16.16; accumulators are wider and saturate.
package pagerank_fx_pkg;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 40;
  localparam int FX_FRAC = 16;
  localparam logic [63:0] FX_ONE = 64'd1 << FX_FRAC;

  typedef logic [DATA_W-1:0] rank_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [31:0]       node_id_t;

  typedef enum logic [2:0] {IDLE, GATHER, FINALIZE, CHECK, DONE} state_t;

  function automatic acc_t sat_add(input acc_t a, input acc_t b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/pagerank_lane_arbiter.sv
// Fixed-priority arbiter: one-hot grant on the lowest-index valid lane.
module pagerank_lane_arbiter #(
  parameter int LANES = 8
) (
  input  logic [LANES-1:0] valid,
  output logic [LANES-1:0] grant
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = valid & (~valid + LANES'(1));

endmodule

// File: rtl/pagerank_gather_accum.sv
// Gathers per-lane rank contributions into per-node accumulators, then applies damping,
// updates the rank vector and decides between another scatter pass and completion.
module pagerank_gather_accum
  import pagerank_fx_pkg::*;
#(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32,
  parameter int MAX_ITER       = 64
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        pagerank_enable,
  input  logic [15:0]                                 damping_factor,
  input  logic [DATA_W-1:0]                           threshold,
  input  logic [NUM_HW_THREADS-1:0][DATA_W-1:0]       pagerank_stream,
  input  logic [NUM_HW_THREADS-1:0][31:0]             dest_update,
  input  logic [NUM_HW_THREADS-1:0]                   stream_valid,
  output logic [NUM_HW_THREADS-1:0]                   stream_ready,
  input  logic                                        DMP_operation_complete,
  output logic [NODES_IN_GRAPH-1:0][DATA_W-1:0]       pagerank_final,
  output logic [31:0]                                 iteration_number,
  output logic                                        nextIteration,
  output logic                                        pagerank_complete
);

  localparam int          K_W       = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam logic [63:0] INV_N     = (64'd1 << 32) / NODES_IN_GRAPH;
  localparam rank_t       INIT_RANK = rank_t'(FX_ONE / NODES_IN_GRAPH);

  state_t                          state_q, state_d;
  acc_t  [NODES_IN_GRAPH-1:0]      acc_q, acc_d;
  rank_t [NODES_IN_GRAPH-1:0]      rank_q, rank_d;
  logic  [31:0]                    iter_q, iter_d;
  rank_t                           delta_q, delta_d;
  logic  [K_W-1:0]                 k_q, k_d;
  logic                            next_iter_q, next_iter_d;
  logic                            complete_q, complete_d;
  logic                            err_oob_q, err_oob_d;

  logic [NUM_HW_THREADS-1:0] grant;
  logic                      beat_fire;
  rank_t                     beat_data;
  node_id_t                  beat_dest;
  logic [63:0]               base_prod, node_wide;
  rank_t                     node_new, node_old, node_diff;
  logic [DATA_W:0]           delta_sum;

  pagerank_lane_arbiter #(.LANES(NUM_HW_THREADS)) u_arb (
    .valid (stream_valid),
    .grant (grant)
  );

  assign stream_ready = (state_q == GATHER) ? grant : '0;
  assign beat_fire    = (state_q == GATHER) && (|stream_valid);

  always_comb begin
    beat_data = '0;
    beat_dest = '0;
    for (int i = 0; i < NUM_HW_THREADS; i++) begin
      if (grant[i]) begin
        beat_data = pagerank_stream[i];
        beat_dest = dest_update[i];
      end
    end
  end

  // Damped update of node k: BASE = (1-d)/N, scaled contribution = d*acc.
  always_comb begin
    node_old  = rank_q[k_q];
    base_prod = (FX_ONE - 64'(damping_factor)) * INV_N;
    node_wide = ((64'(damping_factor) * 64'(acc_q[k_q])) >> FX_FRAC) + (base_prod >> 32);
    node_new  = (|node_wide[63:DATA_W]) ? '1 : node_wide[DATA_W-1:0];
    node_diff = (node_new >= node_old) ? node_new - node_old : node_old - node_new;
    delta_sum = {1'b0, delta_q} + {1'b0, node_diff};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rank_d      = rank_q;
    iter_d      = iter_q;
    delta_d     = delta_q;
    k_d         = k_q;
    next_iter_d = 1'b0;
    complete_d  = complete_q;
    err_oob_d   = err_oob_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (pagerank_enable) begin
          rank_d     = {NODES_IN_GRAPH{INIT_RANK}};
          acc_d      = '0;
          iter_d     = '0;
          delta_d    = '0;
          k_d        = '0;
          complete_d = 1'b0;
          state_d    = GATHER;
        end
      end
      GATHER: begin
        // Lanes still holding beats take precedence over the end-of-pass marker.
        if (beat_fire) begin
          if (beat_dest < 32'(NODES_IN_GRAPH)) begin
            acc_d[beat_dest[K_W-1:0]] = sat_add(acc_q[beat_dest[K_W-1:0]], ACC_W'(beat_data));
          end else begin
            err_oob_d = 1'b1;
          end
        end else if (DMP_operation_complete) begin
          k_d     = '0;
          state_d = FINALIZE;
        end
      end
      FINALIZE: begin
        rank_d[k_q] = node_new;
        acc_d[k_q]  = '0;
        delta_d     = delta_sum[DATA_W] ? '1 : delta_sum[DATA_W-1:0];
        if (k_q == K_W'(NODES_IN_GRAPH - 1)) begin
          k_d     = '0;
          state_d = CHECK;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      CHECK: begin
        iter_d = iter_q + 32'd1;
        if ((delta_q <= threshold) || (iter_d == 32'(MAX_ITER))) begin
          complete_d = 1'b1;
          state_d    = DONE;
        end else begin
          next_iter_d = 1'b1;
          delta_d     = '0;
          state_d     = GATHER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rank_q      <= '0;
      iter_q      <= '0;
      delta_q     <= '0;
      k_q         <= '0;
      next_iter_q <= 1'b0;
      complete_q  <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rank_q      <= rank_d;
      iter_q      <= iter_d;
      delta_q     <= delta_d;
      k_q         <= k_d;
      next_iter_q <= next_iter_d;
      complete_q  <= complete_d;
      err_oob_q   <= err_oob_d;
    end
  end

  assign pagerank_final    = rank_q;
  assign iteration_number  = iter_q;
  assign nextIteration     = next_iter_q;
  assign pagerank_complete = complete_q;

endmodule

// File: tb/tb_pagerank_gather_accum.sv
// Scoreboard bench: each planned iteration pushes its expected outcome; a monitor pops
// and compares whenever the DUT pulses nextIteration or raises pagerank_complete.
module tb_pagerank_gather_accum;

  localparam int LANES = 8;
  localparam int N     = 4;
  localparam int MAXI  = 3;
  localparam longint unsigned ACC_MAX  = (64'd1 << 40) - 1;
  localparam longint unsigned RANK_MAX = 64'hFFFF_FFFF;

  typedef struct {
    int          lane;
    logic [31:0] val;
    logic [31:0] dest;
  } beat_t;

  typedef struct {
    logic [N-1:0][31:0] ranks;
    int                 iter;
    bit                 done;
  } exp_t;

  logic                       clock;
  logic                       reset;
  logic                       pagerank_enable;
  logic [15:0]                damping_factor;
  logic [31:0]                threshold;
  logic [LANES-1:0][31:0]     pagerank_stream;
  logic [LANES-1:0][31:0]     dest_update;
  logic [LANES-1:0]           stream_valid;
  logic [LANES-1:0]           stream_ready;
  logic                       DMP_operation_complete;
  logic [N-1:0][31:0]         pagerank_final;
  logic [31:0]                iteration_number;
  logic                       nextIteration;
  logic                       pagerank_complete;

  pagerank_gather_accum #(
    .NUM_HW_THREADS (LANES),
    .NODES_IN_GRAPH (N),
    .MAX_ITER       (MAXI)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .pagerank_enable        (pagerank_enable),
    .damping_factor         (damping_factor),
    .threshold              (threshold),
    .pagerank_stream        (pagerank_stream),
    .dest_update            (dest_update),
    .stream_valid           (stream_valid),
    .stream_ready           (stream_ready),
    .DMP_operation_complete (DMP_operation_complete),
    .pagerank_final         (pagerank_final),
    .iteration_number       (iteration_number),
    .nextIteration          (nextIteration),
    .pagerank_complete      (pagerank_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  exp_t            exp_q[$];
  beat_t           lane_q[LANES][$];
  longint unsigned model_rank[N];
  int              model_iter;
  logic [15:0]     cur_d;
  logic [31:0]     cur_thr;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic note_timeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic beat_t mk(input int lane, input logic [31:0] val, input logic [31:0] dest);
    beat_t b;
    b.lane = lane;
    b.val  = val;
    b.dest = dest;
    return b;
  endfunction

  function automatic void build_random(output beat_t b[$], input int count, input bit big);
    b.delete();
    for (int j = 0; j < count; j++) begin
      logic [31:0] v;
      logic [31:0] dst;
      v   = (big && ($urandom_range(0, 3) == 0)) ? $urandom : 32'($urandom_range(0, 32'h3FFFF));
      dst = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, N + 1));
      b.push_back(mk($urandom_range(0, LANES - 1), v, dst));
    end
  endfunction

  // Reference: sum contributions per node, then rank = (1-d)/N + d*sum, all in Q16.16.
  function automatic bit plan(input beat_t b[$]);
    longint unsigned acc[N];
    longint unsigned base, nv, diff, delta;
    exp_t e;
    foreach (acc[n]) acc[n] = 0;
    foreach (b[j]) begin
      if (b[j].dest < N) begin
        acc[b[j].dest] += 64'(b[j].val);
        if (acc[b[j].dest] > ACC_MAX) acc[b[j].dest] = ACC_MAX;
      end
    end
    base  = ((64'd65536 - 64'(cur_d)) * ((64'd1 << 32) / N)) >> 32;
    delta = 0;
    for (int n = 0; n < N; n++) begin
      nv = base + ((64'(cur_d) * acc[n]) >> 16);
      if (nv > RANK_MAX) nv = RANK_MAX;
      diff  = (nv >= model_rank[n]) ? nv - model_rank[n] : model_rank[n] - nv;
      delta = delta + diff;
      if (delta > RANK_MAX) delta = RANK_MAX;
      model_rank[n] = nv;
      e.ranks[n]    = 32'(nv);
    end
    model_iter++;
    e.iter = model_iter;
    e.done = (delta <= 64'(cur_thr)) || (model_iter == MAXI);
    exp_q.push_back(e);
    return e.done;
  endfunction

  function automatic logic [LANES-1:0] lowest_valid(input logic [LANES-1:0] v);
    logic [LANES-1:0] g;
    g = '0;
    for (int i = 0; i < LANES; i++) begin
      if (v[i]) begin
        g[i] = 1'b1;
        break;
      end
    end
    return g;
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < LANES; i++) s += lane_q[i].size();
    return s;
  endfunction

  task automatic enqueue(input beat_t b[$]);
    foreach (b[j]) lane_q[b[j].lane].push_back(b[j]);
  endtask

  task automatic present();
    for (int i = 0; i < LANES; i++) begin
      if (lane_q[i].size() > 0) begin
        stream_valid[i]    = 1'b1;
        pagerank_stream[i] = lane_q[i][0].val;
        dest_update[i]     = lane_q[i][0].dest;
      end else begin
        stream_valid[i]    = 1'b0;
        pagerank_stream[i] = $urandom;
        dest_update[i]     = $urandom;
      end
    end
  endtask

  task automatic start_session(input logic [15:0] d, input logic [31:0] thr);
    damping_factor  = d;
    threshold       = thr;
    cur_d           = d;
    cur_thr         = thr;
    pagerank_enable = 1'b1;
    @(negedge clock);
    pagerank_enable = 1'b0;
    model_iter      = 0;
    for (int n = 0; n < N; n++) begin
      model_rank[n] = 65536 / N;
      check_output($sformatf("init_rank[%0d]", n), pagerank_final[n], 64'(65536 / N));
    end
    check_output("init_iteration", iteration_number, 0);
    check_output("init_complete", pagerank_complete, 0);
  endtask

  // Called on a negedge in GATHER; returns on the negedge after FINALIZE has been entered.
  task automatic apply_stimulus(input bit poke_enable);
    int  complete_at;
    int  cycles;
    bit  finished;
    logic [LANES-1:0] g;
    complete_at = $urandom_range(0, pending());
    cycles      = 0;
    finished    = 0;
    while (!finished) begin
      present();
      pagerank_enable        = poke_enable && (cycles == 0);
      DMP_operation_complete = (pending() <= complete_at);
      #1;
      g = lowest_valid(stream_valid);
      check_output("lane_grant", stream_ready, g);
      if (g != '0) begin
        for (int i = 0; i < LANES; i++) if (g[i]) void'(lane_q[i].pop_front());
      end else if (DMP_operation_complete) begin
        finished = 1;
      end
      @(negedge clock);
      cycles++;
      if (!finished && cycles > 500) begin
        note_timeout("gather_drain");
        finished = 1;
      end
    end
    pagerank_enable        = 1'b0;
    DMP_operation_complete = 1'b0;
    present();
  endtask

  task automatic wait_result(input bit backpressure);
    int cycles;
    cycles = 0;
    present();
    while (!(nextIteration || pagerank_complete)) begin
      if (backpressure) check_output("backpressure_ready", stream_ready, 0);
      @(negedge clock);
      cycles++;
      if (cycles > 100) begin
        note_timeout("iteration_result");
        break;
      end
    end
  endtask

  task automatic run_until_done(input int max_beats, input bit big, input bit poke_first);
    beat_t b[$];
    bit    done;
    bit    poke;
    done = 0;
    poke = poke_first;
    while (!done) begin
      build_random(b, $urandom_range(0, max_beats), big);
      done = plan(b);
      enqueue(b);
      apply_stimulus(poke);
      poke = 0;
      wait_result(0);
    end
  endtask

  task automatic check_reset_values();
    for (int n = 0; n < N; n++)
      check_output($sformatf("reset_rank[%0d]", n), pagerank_final[n], 0);
    check_output("reset_iteration", iteration_number, 0);
    check_output("reset_next", nextIteration, 0);
    check_output("reset_complete", pagerank_complete, 0);
    check_output("reset_ready", stream_ready, 0);
  endtask

  // Monitor: every nextIteration pulse or pagerank_complete rise consumes one expectation.
  exp_t mon_e;
  bit   complete_prev = 0;
  bit   next_prev     = 0;
  always @(negedge clock) begin
    if (reset) begin
      complete_prev = 0;
      next_prev     = 0;
    end else begin
      if (next_prev) check_output("next_pulse_width", nextIteration, 0);
      if (nextIteration || (pagerank_complete && !complete_prev)) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_result: next=%0b complete=%0b with nothing expected",
                   nextIteration, pagerank_complete);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("result_kind", {nextIteration, pagerank_complete}, mon_e.done ? 2'b01 : 2'b10);
          check_output("iteration", iteration_number, 64'(mon_e.iter));
          for (int n = 0; n < N; n++)
            check_output($sformatf("rank[%0d]", n), pagerank_final[n], mon_e.ranks[n]);
        end
      end
      complete_prev = pagerank_complete;
      next_prev     = nextIteration;
    end
  end

  initial begin
    beat_t b[$];
    reset                  = 1'b1;
    pagerank_enable        = 1'b0;
    damping_factor         = '0;
    threshold              = '0;
    stream_valid           = '1;
    pagerank_stream        = '0;
    dest_update            = '0;
    DMP_operation_complete = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values();
    reset        = 1'b0;
    stream_valid = '0;
    @(negedge clock);

    // Session A: single contribution, then two-lane collision held under back-pressure, then cap.
    start_session(16'h8000, 32'h0);
    b.delete();
    b.push_back(mk(0, 32'h0001_0000, 32'd2));
    void'(plan(b));
    enqueue(b);
    apply_stimulus(0);
    b.delete();
    b.push_back(mk(0, 32'h0000_4000, 32'd1));
    b.push_back(mk(3, 32'h0000_C000, 32'd1));
    void'(plan(b));
    enqueue(b);
    wait_result(1);
    check_output("a_node2", pagerank_final[2], 32'h0000_A000);
    check_output("a_node0", pagerank_final[0], 32'h0000_2000);
    check_output("a_iteration1", iteration_number, 1);
    apply_stimulus(0);
    wait_result(0);
    check_output("a_node1", pagerank_final[1], 32'h0000_A000);
    run_until_done(10, 0, 0);
    check_output("a_cap_iteration", iteration_number, MAXI);
    check_output("a_cap_complete", pagerank_complete, 1);

    // Session B: d = 0 means every node lands on BASE = INIT_RANK, so it converges at once.
    start_session(16'h0000, 32'h0);
    run_until_done(8, 0, 0);
    for (int n = 0; n < N; n++)
      check_output($sformatf("b_rank[%0d]", n), pagerank_final[n], 32'h0000_4000);
    check_output("b_iteration", iteration_number, 1);

    // Session C: random damping/threshold, large contributions, stray enable during GATHER.
    start_session(16'($urandom), 32'($urandom_range(0, 32'h30000)));
    run_until_done(14, 1, 1);
    check_output("c_complete", pagerank_complete, 1);

    // Session D: reset lands mid-FINALIZE, then a fresh run restarts cleanly.
    start_session(16'h6000, 32'h0);
    build_random(b, 6, 0);
    enqueue(b);
    apply_stimulus(0);
    repeat (2) @(negedge clock);
    reset        = 1'b1;
    stream_valid = '1;
    @(negedge clock);
    check_reset_values();
    foreach (lane_q[i]) lane_q[i].delete();
    stream_valid = '0;
    reset        = 1'b0;
    @(negedge clock);
    start_session(16'hD000, 32'hFFFF_FFFF);
    run_until_done(8, 0, 0);
    check_output("d_iteration", iteration_number, 1);

    repeat (3) @(negedge clock);
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
